program_memory_arbiter: RTL and testbench
=========================================

Name: program_memory_arbiter

Overview:
Shares one single-port, synchronous-read program memory between the core instruction-fetch port and a debug/loader port. The debug/loader port can both read and write, so programs can be loaded or patched at run time. The block sits between the fetch stage and the program memory array. It owns arbitration, word-address translation, range/alignment checking and read-data return routing.

Parameters:
DATA_WIDTH, 32, width of instruction/data words and byte addresses
MEMORY_DEPTH, 64, number of words in the program memory (power of two)
MEM_AW, $clog2(MEMORY_DEPTH), word-index width driven to memory
MAX_DBG_BURST, 4, consecutive debug grants allowed while fetch waits (1..15)
NOP_INSTR, 32'h00000013, word returned to fetch on an error access

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
fetch_req_i  input  1  fetch read request; held with address until granted
fetch_addr_i  input  DATA_WIDTH  fetch byte address
fetch_gnt_o  output  1  fetch request accepted this cycle (combinational)
fetch_rvalid_o  output  1  fetch read data valid (one cycle after grant)
fetch_rdata_o  output  DATA_WIDTH  fetch read data
fetch_err_o  output  1  with fetch_rvalid_o: misaligned or out-of-range access
dbg_halt_i  input  1  when high, no fetch grants are issued
dbg_req_i  input  1  debug access request; held with operands until granted
dbg_we_i  input  1  1 = write, 0 = read
dbg_addr_i  input  DATA_WIDTH  debug byte address
dbg_wdata_i  input  DATA_WIDTH  debug write data
dbg_gnt_o  output  1  debug request accepted this cycle (combinational)
dbg_rvalid_o  output  1  debug response valid, for reads and writes, one cycle after grant
dbg_rdata_o  output  DATA_WIDTH  debug read data; 0 for writes
dbg_err_o  output  1  with dbg_rvalid_o: misaligned or out-of-range access
mem_en_o  output  1  memory access enable
mem_we_o  output  1  memory write enable
mem_addr_o  output  MEM_AW  word index
mem_wdata_o  output  DATA_WIDTH  memory write data
mem_rdata_i  input  DATA_WIDTH  memory read data; valid the cycle after mem_en_o && !mem_we_o

Behaviour:
- Reset: clk and reset as named above; reset is synchronous, active-high.
  - All outputs are 0 during and after reset.
  - burst counter = 0; response-owner register = NONE.
  - A response pending when reset asserts is dropped. No rvalid appears in the cycle after reset.
- Address checks, per request:
  - Word index = addr[MEM_AW+1:2].
  - Misaligned: addr[1:0] != 0.
  - Out-of-range: addr[DATA_WIDTH-1:MEM_AW+2] != 0.
  - Either condition is an error access.
- Eligibility:
  - Fetch is eligible when fetch_req_i && !dbg_halt_i.
  - Debug is eligible when dbg_req_i.
- Arbitration, at most one grant per cycle:
  - Debug only eligible: debug granted.
  - Fetch only eligible: fetch granted.
  - Both eligible: debug granted unless burst counter == MAX_DBG_BURST, in which case fetch is granted.
- Burst counter:
  - Increments on each debug grant issued while fetch is eligible; saturates at MAX_DBG_BURST.
  - Clears on any fetch grant, or in any cycle fetch is not eligible.
- Memory drive on a grant:
  - Non-error: mem_en_o = 1, mem_addr_o = word index, mem_we_o = dbg_we_i for debug (0 for fetch), mem_wdata_o = dbg_wdata_i.
  - Error: mem_en_o = 0, so memory is never touched.
  - No grant: mem_en_o = 0 and mem_we_o = 0.
- Response pipeline:
  - A registered owner ({FETCH, DBG, NONE}), error flag and write flag capture the grant.
  - Next cycle the owner's rvalid pulses for exactly one cycle.
  - rdata for a non-error read = mem_rdata_i.
  - Fetch error: rdata = NOP_INSTR, fetch_err_o = 1.
  - Debug error: rdata = 0, dbg_err_o = 1.
  - Debug write: rdata = 0.
  - rdata outputs are 0 when the matching rvalid is low.
- Throughput:
  - Back-to-back grants are allowed every cycle; latency is fixed at 1 cycle.
  - No internal buffering; a requester stalls by holding req until gnt.
- Read-after-write: a debug write in cycle N followed by a fetch read of the same word in N+1 returns the new data. The memory is write-first/synchronous; no forwarding is needed here.
- dbg_halt_i rising while fetch_req_i is held: the fetch grant is withheld from that cycle on. A response already granted still returns.

Test Plan:
- Reset, then fetch_req_i = 1 with addr 0x0, 0x4, 0x8 on consecutive grants -> fetch_gnt_o high each cycle; fetch_rvalid_o one cycle later with rom[0], rom[1], rom[2]; dbg_* silent.
- dbg write addr 0x10, data 0xDEADBEEF; next cycle fetch 0x10 -> dbg_rvalid_o with rdata 0 and no error, then fetch_rdata_o = 0xDEADBEEF.
- fetch_req_i and dbg_req_i held high continuously, MAX_DBG_BURST = 4 -> grant sequence D,D,D,D,F,D,D,D,D,F; counter clears after each fetch grant.
- Fetch addr 0x102 (misaligned), then fetch addr 0x100 with depth 64 (out of range) -> mem_en_o = 0 both cycles; fetch_rvalid_o with fetch_rdata_o = 0x00000013 and fetch_err_o = 1.
- dbg_halt_i = 1 with fetch_req_i = 1 for 5 cycles -> fetch_gnt_o stays 0; debug reads granted every cycle; burst counter stays 0.
- Grant issued in cycle N, reset asserted in N+1 -> no rvalid in N+1 or N+2; all outputs 0 until a new request after reset deasserts.

Source files
------------

// File: rtl/program_memory_arbiter.sv
// Arbitrates one synchronous-read program memory between instruction fetch and a
// debug/loader port, with address checking and one-cycle response routing.
module program_memory_arbiter #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    MEMORY_DEPTH  = 64,
  parameter int                    MEM_AW        = $clog2(MEMORY_DEPTH),
  parameter int                    MAX_DBG_BURST = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR     = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req_i,
  input  logic [DATA_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_gnt_o,
  output logic                  fetch_rvalid_o,
  output logic [DATA_WIDTH-1:0] fetch_rdata_o,
  output logic                  fetch_err_o,
  input  logic                  dbg_halt_i,
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [DATA_WIDTH-1:0] dbg_addr_i,
  input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
  output logic                  dbg_gnt_o,
  output logic                  dbg_rvalid_o,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  output logic                  dbg_err_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CW = $clog2(MAX_DBG_BURST + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DBG} owner_t;

  logic [CW-1:0]         burst_cnt;
  owner_t                owner_q;
  logic                  err_q;
  logic                  we_q;
  logic                  fetch_elig;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_addr;

  assign fetch_elig = fetch_req_i && !dbg_halt_i;

  // Grants are suppressed while reset is high so every output reads 0 then.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    dbg_gnt_o   = 1'b0;
    fetch_gnt_o = 1'b0;
    if (!reset) begin
      dbg_gnt_o   = dbg_req_i && !(fetch_elig && burst_cnt == CW'(MAX_DBG_BURST));
      fetch_gnt_o = fetch_elig && !dbg_gnt_o;
    end
  end

  assign sel_addr = dbg_gnt_o ? dbg_addr_i : fetch_addr_i;
  assign sel_err  = (sel_addr[1:0] != 2'b00) || ((sel_addr >> (MEM_AW + 2)) != '0);

  // Error accesses never reach the array; idle memory pins are held at 0.
  assign mem_en_o    = (fetch_gnt_o || dbg_gnt_o) && !sel_err;
  assign mem_we_o    = mem_en_o && dbg_gnt_o && dbg_we_i;
  assign mem_addr_o  = mem_en_o ? sel_addr[MEM_AW+1:2] : '0;
  assign mem_wdata_o = mem_en_o ? dbg_wdata_i : '0;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (reset) begin
      burst_cnt <= '0;
      owner_q   <= OWN_NONE;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      if (fetch_gnt_o || !fetch_elig)
        burst_cnt <= '0;
      else if (dbg_gnt_o && burst_cnt != CW'(MAX_DBG_BURST))
        burst_cnt <= burst_cnt + 1'b1;

      if (fetch_gnt_o)    owner_q <= OWN_FETCH;
      else if (dbg_gnt_o) owner_q <= OWN_DBG;
      else                owner_q <= OWN_NONE;

      err_q <= sel_err;
      we_q  <= dbg_gnt_o && dbg_we_i;
    end
  end

  // Responses are gated by reset so a grant made just before reset is dropped.
  assign fetch_rvalid_o = !reset && owner_q == OWN_FETCH;
  assign fetch_err_o    = fetch_rvalid_o && err_q;
  assign fetch_rdata_o  = !fetch_rvalid_o ? '0 : (err_q ? NOP_INSTR : mem_rdata_i);

  assign dbg_rvalid_o = !reset && owner_q == OWN_DBG;
  assign dbg_err_o    = dbg_rvalid_o && err_q;
  assign dbg_rdata_o  = (dbg_rvalid_o && !err_q && !we_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Randomized scoreboard bench for program_memory_arbiter: a driver predicts grants
// and queues responses; a monitor pops and compares whenever rvalid appears.
module tb_program_memory_arbiter;
  localparam int          DW    = 32;
  localparam int          DEPTH = 64;
  localparam int          AW    = 6;
  localparam int          MAXB  = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_req = 1'b0, dbg_halt = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [DW-1:0] fetch_addr = '0, dbg_addr = '0, dbg_wdata = '0;
  logic          fetch_gnt, fetch_rvalid, fetch_err, dbg_gnt, dbg_rvalid, dbg_err;
  logic [DW-1:0] fetch_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  program_memory_arbiter #(.DATA_WIDTH(DW), .MEMORY_DEPTH(DEPTH), .MEM_AW(AW),
                           .MAX_DBG_BURST(MAXB), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
    .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata), .fetch_err_o(fetch_err),
    .dbg_halt_i(dbg_halt), .dbg_req_i(dbg_req), .dbg_we_i(dbg_we),
    .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(dbg_gnt),
    .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Write-first synchronous memory, preloaded on the first edge.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= rom_word(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
    end
  end

  typedef struct {int due; logic [31:0] data; logic err;} resp_t;
  resp_t fq[$];
  resp_t dq[$];

  int          total = 0;
  int          bad = 0;
  logic [31:0] ref_mem [DEPTH];
  int          waited = 0;     // debug grants fetch has sat through
  bit          post_reset = 1'b0;
  bit          last_fg, last_dg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input bit rst, input bit fr, input logic [31:0] fa, input bit halt,
                       input bit dr, input bit dwe, input logic [31:0] da,
                       input logic [31:0] dwd);
    bit fe, eg_f, eg_d, err;
    logic [31:0] a;
    int idx;
    resp_t r;
    @(negedge clk);
    reset = rst; fetch_req = fr; fetch_addr = fa; dbg_halt = halt;
    dbg_req = dr; dbg_we = dwe; dbg_addr = da; dbg_wdata = dwd;
    #1;
    if (rst) begin
      eg_f = 0; eg_d = 0; waited = 0; post_reset = 1'b1;
      fq.delete(); dq.delete();
    end else begin
      fe   = fr && !halt;
      eg_d = dr && !(fe && waited >= MAXB);
      eg_f = fe && !eg_d;
      if (eg_f || !fe) waited = 0;
      else if (eg_d && waited < MAXB) waited++;
      if (fr || dr) post_reset = 1'b0;
    end
    last_fg = eg_f; last_dg = eg_d;
    check("fetch_gnt", 32'(fetch_gnt), 32'(eg_f));
    check("dbg_gnt", 32'(dbg_gnt), 32'(eg_d));
    if (rst || post_reset)
      check("quiet_outputs", {fetch_rvalid, fetch_err, dbg_rvalid, dbg_err, mem_en, mem_we,
                              26'(mem_addr) | 26'(fetch_rdata | dbg_rdata | mem_wdata)}, 32'h0);
    if (eg_f || eg_d) begin
      a   = eg_d ? da : fa;
      err = (a[1:0] != 0) || (a >= 32'(DEPTH * 4));
      idx = int'(a[7:2]);
      r.due = cyc + 1;
      r.err = err;
      if (err) begin
        check("mem_en_err", 32'(mem_en), 32'h0);
        r.data = eg_f ? NOP : 32'h0;
      end else begin
        check("mem_en", 32'(mem_en), 32'h1);
        check("mem_we", 32'(mem_we), 32'(eg_d && dwe));
        check("mem_addr", 32'(mem_addr), 32'(idx));
        check("mem_wdata", mem_wdata, dwd);
        r.data = (eg_d && dwe) ? 32'h0 : ref_mem[idx];
        if (eg_d && dwe) ref_mem[idx] = dwd;
      end
      if (eg_f) fq.push_back(r);
      else dq.push_back(r);
    end else begin
      check("mem_idle", {30'h0, mem_en, mem_we}, 32'h0);
    end
  endtask

  task automatic mon_port(input string nm, input bit v, input logic [31:0] d, input bit e,
                          inout resp_t q[$]);
    resp_t r;
    if (v) begin
      if (q.size() == 0) begin
        check({nm, "_spurious_rvalid"}, 32'h1, 32'h0);
      end else begin
        r = q.pop_front();
        check({nm, "_rvalid_cycle"}, 32'(cyc), 32'(r.due));
        check({nm, "_rdata"}, d, r.data);
        check({nm, "_err"}, 32'(e), 32'(r.err));
      end
    end else begin
      check({nm, "_idle_rdata"}, d | 32'(e), 32'h0);
      if (q.size() != 0 && q[0].due <= cyc) begin
        check({nm, "_missing_rvalid"}, 32'h0, 32'h1);
        void'(q.pop_front());
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      mon_port("fetch", fetch_rvalid, fetch_rdata, fetch_err, fq);
      mon_port("dbg", dbg_rvalid, dbg_rdata, dbg_err, dq);
    end
  end

  function automatic logic [31:0] rand_addr();
    int r = int'($urandom_range(0, 15));
    if (r == 0) return ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
    if (r == 1) return ($urandom & 32'hFFFF_FFFC) | 32'h0000_0100;
    if (r < 8)  return $urandom_range(0, 7) * 4;
    return $urandom_range(0, DEPTH - 1) * 4;
  endfunction

  initial begin
    bit fr, dr, dwe, halt;
    logic [31:0] fa, da, dwd;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = rom_word(i);

    // Requests held during reset must not be granted.
    repeat (2) cycle(1, 1, 32'h0, 0, 1, 0, 32'h4, 32'h0);
    cycle(0, 1, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    cycle(0, 1, 32'h4, 0, 0, 0, 32'h0, 32'h0);
    cycle(0, 1, 32'h8, 0, 0, 0, 32'h0, 32'h0);
    // Write then immediately fetch the same word.
    cycle(0, 0, 32'h0, 0, 1, 1, 32'h10, 32'hDEADBEEF);
    cycle(0, 1, 32'h10, 0, 0, 0, 32'h0, 32'h0);
    // Both held: debug bursts of MAXB then one fetch.
    repeat (10) cycle(0, 1, 32'h20, 0, 1, 0, 32'h24, 32'h0);
    // Misaligned then out-of-range fetch.
    cycle(0, 1, 32'h102, 0, 0, 0, 32'h0, 32'h0);
    cycle(0, 1, 32'h100, 0, 0, 0, 32'h0, 32'h0);
    // Halted fetch never wins; debug reads every cycle.
    for (int i = 0; i < 5; i++) cycle(0, 1, 32'h0, 1, 1, 0, 32'(i * 4), 32'h0);
    // Debug error accesses.
    cycle(0, 0, 32'h0, 0, 1, 0, 32'h3, 32'h0);
    cycle(0, 0, 32'h0, 0, 1, 1, 32'h1000, 32'h1234);
    // Grant then reset: the pending response is dropped.
    cycle(0, 1, 32'h4, 0, 0, 0, 32'h0, 32'h0);
    cycle(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) cycle(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);

    fr = 0; dr = 0; dwe = 0; halt = 0; fa = 0; da = 0; dwd = 0;
    for (int n = 0; n < 600; n++) begin
      if (!fr) begin
        fr = ($urandom_range(0, 3) != 0); fa = rand_addr();
      end
      if (!dr) begin
        dr = ($urandom_range(0, 2) != 0); dwe = $urandom_range(0, 1) == 1;
        da = rand_addr(); dwd = $urandom;
      end
      halt = ($urandom_range(0, 7) == 0);
      cycle(0, fr, fa, halt, dr, dwe, da, dwd);
      if (last_fg) fr = 0;
      if (last_dg) dr = 0;
    end

    repeat (3) cycle(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    check("fetch_queue_drained", 32'(fq.size()), 32'h0);
    check("dbg_queue_drained", 32'(dq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
